// File: rtl/mire_wshb_writer.sv
// mire_wshb_writer: wishbone master painting a grid test pattern into the framebuffer in raster order.
// Optional MIRE_ONESHOT_EN: paint one frame, then release the bus until rst.
module mire_wshb_writer #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int BURST_LEN = 64,
    parameter int GRID      = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    input  logic [31:0] dat_sm,
    output logic        frame_done
);
    localparam int XW = HDISP > 1 ? $clog2(HDISP) : 1;
    localparam int YW = VDISP > 1 ? $clog2(VDISP) : 1;
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
`ifdef MIRE_ONESHOT_EN
    typedef enum logic [1:0] {IDLE, WRITE, PAUSE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;
`endif
    state_t state;
    logic [XW-1:0] x, nx;
    logic [YW-1:0] y, ny;
    logic [BW-1:0] burst_cnt;
    logic acc, last_x, last_y, last, end_burst;
    // err and rty need no handling: without ack nothing advances, so the same word is re-issued
    logic unused_ok;
    assign unused_ok = ^{dat_sm, err, rty};
    assign we  = 1'b1;
    assign sel = 4'hF;
    assign cti = 3'b000;
    assign bte = 2'b00;
    function automatic logic [31:0] pat(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return ((px & XW'(GRID-1)) == '0 || (py & YW'(GRID-1)) == '0 ||
                px == XW'(HDISP-1) || py == YW'(VDISP-1)) ? 32'h00FFFFFF : 32'h0;
    endfunction
    always_comb begin
        acc       = stb & ack;
        last_x    = x == XW'(HDISP-1);
        last_y    = y == YW'(VDISP-1);
        last      = last_x & last_y;
        end_burst = burst_cnt == BW'(BURST_LEN-1) || last;
        nx        = last_x ? '0 : x + 1'b1;
        ny        = last_x ? (last_y ? '0 : y + 1'b1) : y;
    end
    assign frame_done = acc & last;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            adr       <= '0;
            dat_ms    <= pat('0, '0);
            x         <= '0;
            y         <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    state <= WRITE;
                    cyc   <= 1'b1;
                    stb   <= 1'b1;
                end
                WRITE: if (acc) begin
                    x         <= nx;
                    y         <= ny;
                    adr       <= last ? '0 : adr + 32'd4;
                    dat_ms    <= pat(nx, ny);
                    burst_cnt <= end_burst ? '0 : burst_cnt + 1'b1;
                    if (end_burst) begin
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
`ifdef MIRE_ONESHOT_EN
                        state <= last ? DONE : PAUSE;
`else
                        state <= PAUSE;
`endif
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_mire_wshb_writer.sv
// tb_mire_wshb_writer: checks raster addresses, pattern, pauses and frame_done against a counting model.
module tb_mire_wshb_writer;
    logic clk = 0, rst = 1, ack = 0, err = 0, rty = 0;
    logic cyc, stb, we, frame_done;
    logic [31:0] adr, dat_ms, dat_sm;
    logic [3:0] sel;
    logic [2:0] cti;
    logic [1:0] bte;
    int n_chk = 0, n_fail = 0;
    int k, wcnt, gap;
    bit done_m;
    typedef struct { logic [31:0] adr; logic [31:0] dat; } vec_t;
    vec_t tbl[6];
    assign dat_sm = 32'hDEADBEEF;
    always #5 clk = ~clk;
    mire_wshb_writer #(.HDISP(8), .VDISP(4), .BURST_LEN(4), .GRID(4)) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_ms(dat_ms),
        .sel(sel), .cti(cti), .bte(bte), .ack(ack), .err(err), .rty(rty), .dat_sm(dat_sm),
        .frame_done(frame_done));
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction
    function automatic logic [31:0] mpat(input int kk);
        int px = kk % 8, py = (kk / 8) % 4;
        return (px % 4 == 0 || py % 4 == 0 || px == 7 || py == 3) ? 32'h00FFFFFF : 32'h0;
    endfunction
    task automatic step(input logic a, input logic e, input logic r);
        bit act;
        @(negedge clk);
        ack = a; err = e; rty = r;
        #1;
        act = gap == 0 && !done_m;
        chk("cyc", {31'b0, cyc}, {31'b0, act});
        chk("stb", {31'b0, stb}, {31'b0, act});
        chk("adr", adr, 4 * (k % 32));
        chk("dat", dat_ms, mpat(k));
        chk("frame_done", {31'b0, frame_done}, {31'b0, act && a && (k % 32 == 31)});
        if (act && a) begin
            k++; wcnt++;
            if (wcnt == 4 || k % 32 == 0) begin wcnt = 0; gap = 1; end
`ifdef MIRE_ONESHOT_EN
            if (k == 32) done_m = 1;
`endif
        end else if (gap > 0) gap--;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1; ack = 0; err = 0; rty = 0;
        @(negedge clk);
        rst = 0; k = 0; wcnt = 0; gap = 0; done_m = 0;
        #1;
        chk("rst_cyc", {31'b0, cyc}, 0);
        chk("rst_stb", {31'b0, stb}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_ms, 32'h00FFFFFF);
        chk("rst_frame_done", {31'b0, frame_done}, 0);
        chk("we_sel_cti_bte", {24'b0, we, sel, cti}, {24'b0, 1'b1, 4'hF, 3'b000});
    endtask
    task automatic run_to(input int kk);
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (k == kk && gap == 0 && !done_m) begin ok = 1; break; end
            step(1, 0, 0);
        end
        chk("run_to_timeout", {31'b0, ok}, 1);
    endtask
    initial begin
        tbl[0] = '{32'd0, 32'h00FFFFFF};
        tbl[1] = '{32'd20, 32'h00FFFFFF};
        tbl[2] = '{32'd36, 32'h0};
        tbl[3] = '{32'd44, 32'h0};
        tbl[4] = '{32'd48, 32'h00FFFFFF};
        tbl[5] = '{32'd124, 32'h00FFFFFF};
        repeat (3) @(posedge clk);
        do_reset();
        foreach (tbl[i]) begin
            bit found = 0;
            for (int n = 0; n < 200 && !found; n++) begin
                step(1, 0, 0);
                if (cyc && adr == tbl[i].adr) begin
                    chk("pattern", dat_ms, tbl[i].dat);
                    found = 1;
                end
            end
            chk("pattern_timeout", {31'b0, found}, 1);
        end
        repeat (120) step(1, 0, 0);
        do_reset();
        for (int n = 0; n < 150; n++) step(n % 3 == 2, 0, 0);
        do_reset();
        repeat (300) step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        do_reset();
        run_to(5);
        step(0, 1, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 1);
        repeat (10) step(1, 0, 0);
        do_reset();
        run_to(10);
        step(0, 0, 0);
        step(0, 0, 0);
        do_reset();
        repeat (40) step(1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected under 200000", $time);
        $fatal(1);
    end
endmodule
